kyber_zeta_inv_gen: RTL and testbench
=====================================

// Module: kyber_zeta_inv_gen
// PURPOSE
//  Run-time writer for the Kyber inverse-NTT twiddle table: computes 17^-brv7(i) mod 3329
//  for i=0..127 and writes each value into an internal 128x12 RAM.
//  After generation it serves reads through the same ad/ce/oce/dout interface as the
//  Gowin twiddle pROM, so it is a drop-in replacement for the INTT datapath.
//  A run is one pass of 128 sequential modular multiplications by ZETA_INV.
//  Results are written at bit-reversed addresses.
// PARAMETERS
//  Q        3329  Kyber modulus
//  ZETA_INV 1175  17^-1 mod Q; per-step multiplier
//  N        128   table depth (entries)
//  W        12    coefficient width
//  AW       7     address width, log2(N)
// PORTS
//  clk    in   1   system clock, rising edge
//  reset  in   1   asynchronous, active-high reset
//  start  in   1   1-cycle pulse: begin generation; ignored while busy=1
//  busy   out  1   high from the cycle after start until the last write
//  done   out  1   high after a complete pass; cleared by start or reset
//  ad     in   7   read address
//  ce     in   1   read clock enable
//  oce    in   1   output-register enable; kept for port compatibility only
//  dout   out  12  read data
// BEHAVIOUR
//  Reset
//   - busy=0, done=0, dout=0, state=IDLE.
//   - RAM contents are not cleared.
//  Storage and running product
//   - RAM is 128x12 distributed/SSRAM with one write port and one read port.
//   - Running product p is W bits wide; k is the AW-bit step counter.
//  FSM: IDLE -> WRITE -> MUL -> (WRITE | FIN) -> IDLE
//   - IDLE: on start, set p=1 and k=0, clear done, set busy=1, go to WRITE.
//   - WRITE (1 cycle): mem[brv7(k)] <= p.
//     brv7 = bit-reverse of k[6:0]. If k==N-1 go to FIN, else go to MUL.
//   - MUL (12 cycles): double-and-add, bits of ZETA_INV scanned MSB first.
//     Each cycle: a = 2a mod Q; if bit set, a = a + p mod Q.
//     Each mod Q step is one conditional subtract, so a stays in [0, Q-1].
//     At exit: p <= a, k <= k+1, go to WRITE.
//   - FIN (1 cycle): busy=0, done=1, go to IDLE.
//  Timing
//   - One full pass is 128 WRITE + 127*12 MUL + 1 FIN = 1653 cycles after the start edge.
//   - busy is high for exactly 1652 cycles.
//  Arithmetic
//   - 2a <= 6656 and a+p <= 6656, so 13-bit intermediates suffice.
//   - No full-width multiplier is used.
//  Read port
//   - When ce=1 and busy=0: dout <= mem[ad] on the next edge (1-cycle latency).
//     oce has no effect.
//   - When ce=0: dout holds its value.
//   - When ce=1 and busy=1: dout <= 0, because RAM contents are incomplete.
//   - Reads at addresses written earlier in the current pass are also blocked.
//  Boundary conditions
//   - start while busy: ignored, no restart.
//   - start while done=1: done drops next cycle and a new pass begins.
//     The RAM is overwritten with identical values.
//   - reset mid-pass: FSM returns to IDLE; the partially written RAM is left as is.
//     done stays 0 until a complete pass finishes.
//   - k wrap: k never increments past 127; FIN is entered from WRITE when k==127.
// STRUCTURE
//  Shared package kyber_pkg holds:
//   - constants: KYBER_Q=3329, KYBER_ZETA_INV=1175, KYBER_N=128
//   - a brv7 function
//   - FSM state encoding: IDLE/WRITE/MUL/FIN, 2-bit localparam
//  One sub-module, kyber_modmul_seq:
//   - operands: 12-bit operand, 12-bit constant
//   - handshakes: go/ready
//   - fixed 12-cycle latency
//   - reusable by the NTT butterfly controller
//  RAM is inferred inside this module; no vendor primitive is used.
// TESTING
//  T1 Reset, then a single start pulse:
//     busy rises next cycle and falls after 1652 cycles; done=1 at cycle 1653.
//  T2 After done, read addresses 0, 1, 2, 3 and 127 with ce=1:
//     dout = 0x001, 0x640, 0x028, 0x2ED and 0xCF0, each 1 cycle after its ad.
//  T3 Full sweep of ad=0..127:
//     every word equals 17^-brv7(i) mod 3329 from a golden model.
//     All values are < 3329.
//  T4 start pulsed again at cycles 10 and 500 of a pass:
//     both are ignored and total pass length stays 1653 cycles.
//     Reads with ce=1 during busy return 0.
//  T5 reset asserted asynchronously at cycle 700 of a pass:
//     busy, done and dout are 0 immediately.
//     A new start then yields correct T2 values.
//  T6 ce=0 after reading addr 1:
//     dout holds 0x640 while ad changes; oce toggling has no effect on dout.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber constants, bit-reverse helper and generator FSM encoding.
// Imported by the twiddle generator and the sequential modular multiplier.
package kyber_pkg;

  localparam int KYBER_Q        = 3329;
  localparam int KYBER_ZETA_INV = 1175;
  localparam int KYBER_N        = 128;
  localparam int KYBER_W        = 12;
  localparam int KYBER_AW       = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_MUL   = 2'd2,
    S_FIN   = 2'd3
  } gen_state_t;

  function automatic logic [6:0] brv7(input logic [6:0] x);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) begin
      r[i] = x[6-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/kyber_modmul_seq.sv
// Sequential modular multiply a = op * c mod Q, double-and-add, MSB first.
// Fixed 12-cycle latency from go; ready and result are valid on the last step.
module kyber_modmul_seq
  import kyber_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_go,
  input  logic [11:0] i_op,
  input  logic [11:0] i_const,
  output logic        o_ready,
  output logic [11:0] o_res
);

  localparam logic [12:0] Q13 = 13'(KYBER_Q);

  logic [11:0] r_a;
  logic [11:0] r_b;
  logic [11:0] r_c;
  logic [3:0]  r_cnt;
  logic        r_run;

  logic [12:0] w_dbl;
  logic [12:0] w_dmod;
  logic [12:0] w_add;
  logic [12:0] w_amod;
  logic        w_unused_msb;

  // One double-and-add step, each mod Q a single conditional subtract
  always_comb begin
    w_dbl  = {r_a, 1'b0};
    w_dmod = (w_dbl >= Q13) ? w_dbl - Q13 : w_dbl;
    w_add  = w_dmod + (r_c[11] ? {1'b0, r_b} : 13'd0);
    w_amod = (w_add >= Q13) ? w_add - Q13 : w_add;
  end

  assign o_res        = w_amod[11:0];
  assign w_unused_msb = w_amod[12];
  assign o_ready      = r_run && (r_cnt == 4'd11);

  // Load operands on go, then scan constant bits for 12 cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_go) begin
      r_a   <= '0;
      r_b   <= i_op;
      r_c   <= i_const;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_a   <= w_amod[11:0];
      r_c   <= {r_c[10:0], 1'b0};
      r_cnt <= r_cnt + 4'd1;
      if (r_cnt == 4'd11) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/kyber_zeta_inv_gen.sv
// Run-time generator of the inverse-NTT twiddle table (17^-brv7(i) mod Q).
// Serves reads afterwards with the same ad/ce/oce/dout port as the pROM.
module kyber_zeta_inv_gen
  import kyber_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [6:0]  ad,
  input  logic        ce,
  input  logic        oce,
  output logic [11:0] dout
);

  gen_state_t  r_state;
  gen_state_t  w_next;
  logic [11:0] r_p;
  logic [6:0]  r_k;
  logic        r_busy;
  logic        r_done;
  logic [11:0] r_dout;
  logic [11:0] r_mem [0:KYBER_N-1];

  logic        w_go;
  logic        w_we;
  logic        w_mul_ready;
  logic [11:0] w_mul_res;
  logic        w_unused_oce;

  assign w_unused_oce = oce;

  kyber_modmul_seq u_mul (
    .clk     (clk),
    .reset   (reset),
    .i_go    (w_go),
    .i_op    (r_p),
    .i_const (12'(KYBER_ZETA_INV)),
    .o_ready (w_mul_ready),
    .o_res   (w_mul_res)
  );

  // Next-state decode plus write and multiplier launch strobes
  always_comb begin
    w_next = r_state;
    w_go   = 1'b0;
    w_we   = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_WRITE;
      S_WRITE: begin
        w_we = 1'b1;
        if (r_k == 7'(KYBER_N - 1)) begin
          w_next = S_FIN;
        end else begin
          w_next = S_MUL;
          w_go   = 1'b1;
        end
      end
      S_MUL: if (w_mul_ready) w_next = S_WRITE;
      S_FIN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, running product, step counter and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_p    <= 12'd1;
        r_k    <= '0;
        r_done <= 1'b0;
        r_busy <= 1'b1;
      end
      if (r_state == S_WRITE && w_next == S_FIN) r_busy <= 1'b0;
      if (r_state == S_MUL && w_mul_ready) begin
        r_p <= w_mul_res;
        r_k <= r_k + 7'd1;
      end
      if (r_state == S_FIN) r_done <= 1'b1;
    end
  end

  // Table write at the bit-reversed index; contents survive reset
  always_ff @(posedge clk) begin
    if (w_we) r_mem[brv7(r_k)] <= r_p;
  end

  // Registered read; blocked to zero while the table is being rebuilt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout <= '0;
    end else if (ce) begin
      r_dout <= r_busy ? 12'd0 : r_mem[ad];
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign dout = r_dout;

endmodule

// File: tb/tb_kyber_zeta_inv_gen.sv
// Directed bench for the inverse-NTT twiddle generator.
// Golden table is 1175^brv7(i) mod 3329 computed by plain multiplication.
module tb_kyber_zeta_inv_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [6:0]  ad;
  logic        ce;
  logic        oce;
  logic [11:0] dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kyber_zeta_inv_gen dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .ad    (ad),
    .ce    (ce),
    .oce   (oce),
    .dout  (dout)
  );

  function automatic int tb_brv(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 7; i++) begin
      if (x[i]) r = r | (1 << (6 - i));
    end
    return r;
  endfunction

  function automatic int golden(input int i);
    int e;
    int r;
    e = tb_brv(i);
    r = 1;
    for (int j = 0; j < e; j++) r = (r * 1175) % 3329;
    return r;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic read_at(input int a, output logic [11:0] d);
    @(negedge clk);
    ad = a[6:0];
    ce = 1'b1;
    @(negedge clk);
    d = dout;
  endtask

  task automatic wait_pass(output int n);
    n = 0;
    while (busy && n < 3000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %0b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got %0b want 0", done);
    end
    checks++;
    if (dout !== 12'd0) begin
      errors++;
      $display("FAIL reset_dout got %0h want 0", dout);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_pass();
    int n;
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise got %0b want 1", busy);
    end
    wait_pass(n);
    checks++;
    if (n != 1652) begin
      errors++;
      $display("FAIL busy_len got %0d want 1652", n);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_early got %0b want 0", done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_1653 got done=%0b busy=%0b want 1 0", done, busy);
    end
  endtask

  task automatic test_reads();
    int          addrs [5];
    int          exps  [5];
    logic [11:0] d;
    addrs = '{0, 1, 2, 3, 127};
    exps  = '{12'h001, 12'h640, 12'h028, 12'h2ED, 12'hCF0};
    for (int i = 0; i < 5; i++) begin
      read_at(addrs[i], d);
      checks++;
      if (d !== exps[i][11:0]) begin
        errors++;
        $display("FAIL read_%0d got %0h want %0h", addrs[i], d, exps[i]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [11:0] d;
    int          g;
    for (int i = 0; i < 128; i++) begin
      read_at(i, d);
      g = golden(i);
      checks++;
      if (d !== g[11:0]) begin
        errors++;
        $display("FAIL sweep_%0d got %0h want %0h", i, d, g);
      end
      checks++;
      if (d >= 12'd3329) begin
        errors++;
        $display("FAIL range_%0d got %0d want <3329", i, d);
      end
    end
  endtask

  task automatic test_start_ignored();
    int          n;
    int          g;
    logic [11:0] d;
    pulse_start();
    ad = 7'd5;
    ce = 1'b1;
    n  = 0;
    while (busy && n < 3000) begin
      start = (n == 10 || n == 500);
      if (n == 600) begin
        checks++;
        if (dout !== 12'd0) begin
          errors++;
          $display("FAIL busy_read got %0h want 0", dout);
        end
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (n != 1652) begin
      errors++;
      $display("FAIL ignore_len got %0d want 1652", n);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL ignore_done got %0b want 1", done);
    end
    read_at(5, d);
    g = golden(5);
    checks++;
    if (d !== g[11:0]) begin
      errors++;
      $display("FAIL ignore_read got %0h want %0h", d, g);
    end
  endtask

  task automatic test_hold();
    logic [11:0] d;
    read_at(1, d);
    checks++;
    if (d !== 12'h640) begin
      errors++;
      $display("FAIL hold_first got %0h want 640", d);
    end
    ce = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      ad  = 7'((j * 17 + 3) % 128);
      oce = ~oce;
      @(negedge clk);
      checks++;
      if (dout !== 12'h640) begin
        errors++;
        $display("FAIL hold_%0d got %0h want 640", j, dout);
      end
    end
  endtask

  task automatic test_reset_mid();
    int          n;
    int          addrs [5];
    int          exps  [5];
    logic [11:0] d;
    addrs = '{0, 1, 2, 3, 127};
    exps  = '{12'h001, 12'h640, 12'h028, 12'h2ED, 12'hCF0};
    read_at(1, d);
    ce = 1'b0;
    pulse_start();
    repeat (700) @(negedge clk);
    checks++;
    if (dout !== 12'h640 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got dout=%0h busy=%0b want 640 1", dout, busy);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== 12'd0) begin
      errors++;
      $display("FAIL async_rst got busy=%0b done=%0b dout=%0h want 0 0 0",
               busy, done, dout);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_rst got done=%0b busy=%0b want 0 0", done, busy);
    end
    pulse_start();
    wait_pass(n);
    checks++;
    if (n != 1652) begin
      errors++;
      $display("FAIL rerun_len got %0d want 1652", n);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL rerun_done got %0b want 1", done);
    end
    for (int i = 0; i < 5; i++) begin
      read_at(addrs[i], d);
      checks++;
      if (d !== exps[i][11:0]) begin
        errors++;
        $display("FAIL rerun_read_%0d got %0h want %0h", addrs[i], d, exps[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int          n;
    logic [11:0] d;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pre got %0b want 1", done);
    end
    pulse_start();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_clear got done=%0b busy=%0b want 0 1", done, busy);
    end
    wait_pass(n);
    checks++;
    if (n != 1652) begin
      errors++;
      $display("FAIL b2b_len got %0d want 1652", n);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done got %0b want 1", done);
    end
    read_at(127, d);
    checks++;
    if (d !== 12'hCF0) begin
      errors++;
      $display("FAIL b2b_read got %0h want cf0", d);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ce    = 1'b0;
    oce   = 1'b0;
    ad    = 7'd0;
    test_reset();
    test_full_pass();
    test_reads();
    test_sweep();
    test_start_ignored();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
